// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arb_pkg;

  // Arbiter control state: no holder, or one requester owns the resource.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a binary index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_param_pick.sv
// Circular find-first picker: returns the first requester at or after ptr,
// wrapping past N-1 back to 0. Purely combinational so it can be shared by
// single- and multi-channel arbiters.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  localparam logic [IDXW:0] SUM_N = (IDXW+1)'(N);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [IDXW-1:0] off;
  logic [IDXW:0]  sum;

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  assign req_dbl = {req, req};
  assign rot     = N'(req_dbl >> ptr);

  // One-hot mask of the lowest set bit of the rotated vector.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign first[gi] = rot[gi];
      end else begin : g_upper
        assign first[gi] = rot[gi] & ~(|rot[gi-1:0]);
      end
    end
  endgenerate

  // Encode the one-hot offset (OR-reduction is safe because at most one bit is set).
  always_comb begin
    off = '0;
    for (int i = 0; i < N; i++) begin
      if (first[i]) off = off | IDXW'(i);
    end
  end

  // Rotate back: winner = (ptr + offset) mod N.
  assign sum   = {1'b0, off} + {1'b0, ptr};
  assign idx   = (sum >= SUM_N) ? IDXW'(sum - SUM_N) : sum[IDXW-1:0];
  assign found = |req;

endmodule

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with persistent one-hot grant, rotating priority and an
// optional per-holder cycle limit. All outputs come straight from flops.
// The holder-done input is called release_i because "release" is reserved.
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0,
  parameter int IDXW     = idx_w(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic            release_i,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  // Counter only needs to reach MAX_HOLD-1; with MAX_HOLD=0 it is held at
  // zero and collapses to constants in synthesis.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic            grant_valid_q, grant_valid_d;

  logic [IDXW-1:0] next_ptr;
  logic [IDXW-1:0] pick_ptr;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic            holder_req;
  logic            timeout;
  logic            rel_cond;

  // Priority after a release starts just past the outgoing holder; from IDLE
  // the stored pointer is used unchanged.
  assign next_ptr   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
  assign pick_ptr   = (state_q == GRANT) ? next_ptr : ptr_q;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign holder_req = req[grant_idx_q];
  assign timeout    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign rel_cond   = !holder_req || release_i || timeout;

  // Next-state logic: grant from IDLE, hand over or hold while in GRANT.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = GRANT;
          grant_d       = N'(1) << pick_idx;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (rel_cond) begin
          ptr_d      = next_ptr;
          hold_cnt_d = '0;
          if (pick_found) begin
            grant_d       = N'(1) << pick_idx;
            grant_idx_d   = pick_idx;
            grant_valid_d = 1'b1;
          end else begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != '1)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule
